// File: rtl/stream_join_collect.sv
// rtl/stream_join_collect.sv - join N ready-valid input streams into one packed output stream
//
// Purpose: each input delivers exactly one payload per output beat into its own capture
// slot; the packed output beat is offered once every slot is full.
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   inp_valid_i  per-input valid           (N_INP)
//   inp_ready_o  per-input ready           (N_INP)
//   inp_data_i   per-input payloads        (N_INP*DATA_WIDTH, input i at [i*DATA_WIDTH +: DATA_WIDTH])
//   oup_valid_o  output valid
//   oup_ready_i  output ready
//   oup_data_o   joined payload            (same packing as inp_data_i)
// Optional feature macro: COMMON_CELLS_JOIN_REFILL_EN (same-cycle refill on output handshake).

module stream_join_collect #(
    parameter int N_INP      = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [N_INP-1:0]            inp_valid_i,
    output logic [N_INP-1:0]            inp_ready_o,
    input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
    output logic                        oup_valid_o,
    input  logic                        oup_ready_i,
    output logic [N_INP*DATA_WIDTH-1:0] oup_data_o
);

    if (N_INP < 1) begin : g_bad_n_inp
        $fatal(1, "stream_join_collect: N_INP must be >= 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $fatal(1, "stream_join_collect: DATA_WIDTH must be >= 1");
    end

    logic [N_INP-1:0]            full_q;
    logic [N_INP*DATA_WIDTH-1:0] data_q;
    logic [N_INP-1:0]            slot_ready;
    logic [N_INP-1:0]            inp_hs;
    logic                        oup_hs;

    assign oup_valid_o = &full_q;
    assign oup_data_o  = data_q;
    assign oup_hs      = oup_valid_o & oup_ready_i;

`ifdef COMMON_CELLS_JOIN_REFILL_EN
    // A full slot may be refilled in the very cycle its pending beat leaves.
    assign slot_ready = ~full_q | {N_INP{oup_hs}};
`else
    // Ready depends on slot state only, keeping the output side off the input timing path.
    assign slot_ready = ~full_q;
`endif

    // No input may handshake while reset is asserted.
    assign inp_ready_o = rst_ni ? slot_ready : '0;
    assign inp_hs      = inp_valid_i & inp_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q <= '0;
            data_q <= '0;
        end else begin
            for (int i = 0; i < N_INP; i++) begin
                // A refill wins over the clear caused by the output handshake.
                if (inp_hs[i]) begin
                    data_q[i*DATA_WIDTH +: DATA_WIDTH] <= inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                    full_q[i] <= 1'b1;
                end else if (oup_hs) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // Producers must hold valid and data steady until accepted.
    for (genvar g = 0; g < N_INP; g++) begin : g_contract
        a_inp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (rst_ni && inp_valid_i[g] && !inp_ready_o[g]) |=>
            (inp_valid_i[g] && $stable(inp_data_i[g*DATA_WIDTH +: DATA_WIDTH])))
            else $error("stream_join_collect: input %0d dropped valid or changed data", g);
    end
`endif

endmodule

// File: tb/tb_stream_join_collect.sv
// tb/tb_stream_join_collect.sv - directed self-checking bench for stream_join_collect

module tb_stream_join_collect;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  inp_valid_i;
    logic [1:0]  inp_ready_o;
    logic [15:0] inp_data_i;
    logic        oup_valid_o;
    logic        oup_ready_i;
    logic [15:0] oup_data_o;

    int vectors     = 0;
    int miscompares = 0;

    stream_join_collect #(.N_INP(2), .DATA_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .inp_data_i  (inp_data_i),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_data_o  (oup_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    int       edges;
    int       outs;
    int       sent [2];
    logic [1:0] hs_in;
    logic     hs_out;
    int       exp_edges;

    initial begin
        rst_ni      = 1'b0;
        inp_valid_i = 2'b11;
        inp_data_i  = 16'hBBAA;
        oup_ready_i = 1'b0;

        // Reset held for 3 cycles with all inputs valid.
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_ready", inp_ready_o, 2'b00);
            check("rst_valid", oup_valid_o, 1'b0);
        end
        inp_valid_i = 2'b00;
        rst_ni      = 1'b1;
        #1;
        check("post_rst_ready", inp_ready_o, 2'b11);
        check("post_rst_data", oup_data_o, 16'h0000);
        check("post_rst_valid", oup_valid_o, 1'b0);

        // Simultaneous fill.
        inp_valid_i = 2'b11;
        inp_data_i  = 16'hBBAA;
        step();
        inp_valid_i = 2'b00;
        check("sim_valid", oup_valid_o, 1'b1);
        check("sim_data", oup_data_o, 16'hBBAA);

        // Backpressure: new data offered but must not be taken.
        inp_valid_i = 2'b11;
        inp_data_i  = 16'hDDCC;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_ready", inp_ready_o, 2'b00);
            step();
            check("bp_data", oup_data_o, 16'hBBAA);
            check("bp_valid", oup_valid_o, 1'b1);
        end
        oup_ready_i = 1'b1;
        step();
        oup_ready_i = 1'b0;
`ifdef COMMON_CELLS_JOIN_REFILL_EN
        inp_valid_i = 2'b00;
        check("bp_refill_valid", oup_valid_o, 1'b1);
        check("bp_refill_data", oup_data_o, 16'hDDCC);
`else
        check("bp_drain_valid", oup_valid_o, 1'b0);
        step();
        inp_valid_i = 2'b00;
        check("bp_next_valid", oup_valid_o, 1'b1);
        check("bp_next_data", oup_data_o, 16'hDDCC);
`endif
        oup_ready_i = 1'b1;
        step();
        oup_ready_i = 1'b0;
        check("bp_empty", oup_valid_o, 1'b0);

        // Staggered fill: input0 at t, input1 at t+3.
        inp_valid_i = 2'b01;
        inp_data_i  = 16'h0011;
        step();
        inp_valid_i = 2'b00;
        check("stg_ready0", inp_ready_o[0], 1'b0);
        check("stg_valid_t1", oup_valid_o, 1'b0);
        step();
        check("stg_ready0_t2", inp_ready_o[0], 1'b0);
        check("stg_valid_t2", oup_valid_o, 1'b0);
        step();
        check("stg_valid_t3", oup_valid_o, 1'b0);
        inp_valid_i = 2'b10;
        inp_data_i  = 16'h2200;
        step();
        inp_valid_i = 2'b00;
        check("stg_valid_t4", oup_valid_o, 1'b1);
        check("stg_data", oup_data_o, 16'h2211);
        oup_ready_i = 1'b1;
        step();
        oup_ready_i = 1'b0;
        check("stg_empty", oup_valid_o, 1'b0);

        // Reset mid-operation discards the partial beat.
        inp_valid_i = 2'b01;
        inp_data_i  = 16'h0055;
        step();
        inp_valid_i = 2'b00;
        check("mid_partial", oup_valid_o, 1'b0);
        check("mid_ready0_full", inp_ready_o[0], 1'b0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        check("mid_ready", inp_ready_o, 2'b11);
        check("mid_data", oup_data_o, 16'h0000);
        inp_valid_i = 2'b11;
        inp_data_i  = 16'h7766;
        step();
        inp_valid_i = 2'b00;
        check("mid_new_valid", oup_valid_o, 1'b1);
        check("mid_new_data", oup_data_o, 16'h7766);
        oup_ready_i = 1'b1;
        step();
        oup_ready_i = 1'b0;
        check("mid_single", oup_valid_o, 1'b0);

        // Throughput: 20 beats, input0 beat k = k, input1 beat k = 0x40+k.
        sent[0]     = 0;
        sent[1]     = 0;
        edges       = 0;
        outs        = 0;
        oup_ready_i = 1'b1;
        inp_valid_i = 2'b11;
        inp_data_i  = {8'h40, 8'h00};
        while (outs < 20 && edges < 100) begin
            #3;
            hs_in  = inp_valid_i & inp_ready_o;
            hs_out = oup_valid_o & oup_ready_i;
            if (hs_out) begin
                check("tp_order", oup_data_o, {8'h40 + 8'(outs), 8'(outs)});
                outs++;
            end
            step();
            edges++;
            for (int i = 0; i < 2; i++) begin
                if (hs_in[i]) begin
                    sent[i]++;
                    if (sent[i] < 20)
                        inp_data_i[i*8 +: 8] = (i == 0) ? 8'(sent[i]) : 8'h40 + 8'(sent[i]);
                    else
                        inp_valid_i[i] = 1'b0;
                end
            end
        end
        oup_ready_i = 1'b0;
        inp_valid_i = 2'b00;
`ifdef COMMON_CELLS_JOIN_REFILL_EN
        exp_edges = 21;
`else
        exp_edges = 40;
`endif
        check("tp_beats", outs, 20);
        check("tp_cycles", edges, exp_edges);
        step();
        check("tp_idle", oup_valid_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
